// File: rtl/conv_stream_param.sv
// conv_stream_param: streaming 1-D valid-mode convolution.
// Loads LENF coefficients once after reset. For each vector of LENX samples it
// emits LENX-LENF+1 outputs. Products and running sums saturate to signed WIDTH.
// Optional macro CONV_STREAM_RELU_EN clamps each negative final output to zero.
module conv_stream_param #(
    parameter int WIDTH = 16,
    parameter int LENX  = 8,
    parameter int LENF  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data_in_f,
    input  logic             s_valid_f,
    output logic             s_ready_f,
    input  logic [WIDTH-1:0] s_data_in_x,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    output logic [WIDTH-1:0] m_data_out_y,
    output logic             m_valid_y,
    input  logic             m_ready_y
);

    localparam int unsigned XIW = (LENX > 1) ? $clog2(LENX) : 1;
    localparam int unsigned FIW = (LENF > 1) ? $clog2(LENF) : 1;
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic [FIW-1:0] F_LAST = FIW'(LENF - 1);
    localparam logic [XIW-1:0] X_LAST = XIW'(LENX - 1);
    localparam logic [XIW-1:0] K_LAST = XIW'(LENX - LENF);

    localparam logic signed [PW-1:0] SMAX = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        LOAD_F  = 2'd0,
        LOAD_X  = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [FIW-1:0] cnt_f;
    logic [XIW-1:0] cnt_x;
    logic [XIW-1:0] k;
    logic [FIW-1:0] tap;
    logic           issuing;

    logic [WIDTH-1:0] f_mem [LENF];
    logic [WIDTH-1:0] x_mem [LENX];

    logic signed [WIDTH-1:0] rd_x;
    logic signed [WIDTH-1:0] rd_f;
    logic                    v1;
    logic                    first1;
    logic                    last1;
    logic signed [WIDTH-1:0] prod;
    logic                    v2;
    logic                    first2;
    logic                    last2;
    logic signed [WIDTH-1:0] acc;

    logic                    xfer_f_c;
    logic                    xfer_x_c;
    logic                    xfer_y_c;
    logic                    issue_c;
    logic signed [PW-1:0]    mul_c;
    logic signed [WIDTH-1:0] acc_base_c;
    logic signed [PW-1:0]    sum_c;
    logic signed [WIDTH-1:0] sum_sat_c;
    logic [WIDTH-1:0]        y_c;
    logic                    rdy_f_c;
    logic                    rdy_x_c;
    logic                    vld_y_c;

    // Clamp a full-precision value into the signed WIDTH range
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SMAX) begin
            sat = SMAX[WIDTH-1:0];
        end else if (v < SMIN) begin
            sat = SMIN[WIDTH-1:0];
        end else begin
            sat = v[WIDTH-1:0];
        end
    endfunction

    assign xfer_f_c = s_valid_f && s_ready_f;
    assign xfer_x_c = s_valid_x && s_ready_x;
    assign xfer_y_c = m_valid_y && m_ready_y;
    assign issue_c  = (state == COMPUTE) && issuing;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD_F;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            LOAD_F:  if (xfer_f_c && (cnt_f == F_LAST)) state_next = LOAD_X;
            LOAD_X:  if (xfer_x_c && (cnt_x == X_LAST)) state_next = COMPUTE;
            COMPUTE: if (v2 && last2) state_next = OUTPUT;
            OUTPUT:  if (xfer_y_c) state_next = (k == K_LAST) ? LOAD_X : COMPUTE;
            default: state_next = LOAD_F;
        endcase
    end

    // Output decode: handshake flags follow the state being entered
    always_comb begin
        rdy_f_c = 1'b0;
        rdy_x_c = 1'b0;
        vld_y_c = 1'b0;
        rdy_f_c = (state_next == LOAD_F);
        rdy_x_c = (state_next == LOAD_X);
        vld_y_c = (state_next == OUTPUT);
    end

    // Registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            s_ready_f <= 1'b0;
            s_ready_x <= 1'b0;
            m_valid_y <= 1'b0;
        end else begin
            s_ready_f <= rdy_f_c;
            s_ready_x <= rdy_x_c;
            m_valid_y <= vld_y_c;
        end
    end

    // Load counters and output index k
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_f <= '0;
            cnt_x <= '0;
            k     <= '0;
        end else begin
            if (xfer_f_c) cnt_f <= (cnt_f == F_LAST) ? '0 : cnt_f + 1'b1;
            if (xfer_x_c) cnt_x <= (cnt_x == X_LAST) ? '0 : cnt_x + 1'b1;
            if (xfer_y_c) k     <= (k == K_LAST) ? '0 : k + 1'b1;
        end
    end

    // Coefficient and sample storage, written in arrival order
    always_ff @(posedge clk) begin
        if (xfer_f_c) f_mem[cnt_f] <= s_data_in_f;
        if (xfer_x_c) x_mem[cnt_x] <= s_data_in_x;
    end

    // Tap issue: one tap per cycle, restarted on every entry into COMPUTE
    always_ff @(posedge clk) begin
        if (reset) begin
            issuing <= 1'b0;
            tap     <= '0;
        end else if ((state != COMPUTE) && (state_next == COMPUTE)) begin
            issuing <= 1'b1;
            tap     <= '0;
        end else if (issue_c) begin
            if (tap == F_LAST) begin
                issuing <= 1'b0;
            end else begin
                tap <= tap + 1'b1;
            end
        end
    end

    assign mul_c = PW'(rd_x) * PW'(rd_f);

    // Pipeline stages: memory read, then saturated product
    always_ff @(posedge clk) begin
        if (reset) begin
            v1     <= 1'b0;
            first1 <= 1'b0;
            last1  <= 1'b0;
            rd_x   <= '0;
            rd_f   <= '0;
            v2     <= 1'b0;
            first2 <= 1'b0;
            last2  <= 1'b0;
            prod   <= '0;
        end else begin
            v1     <= issue_c;
            first1 <= issue_c && (tap == '0);
            last1  <= issue_c && (tap == F_LAST);
            if (issue_c) begin
                rd_x <= x_mem[k + XIW'(tap)];
                rd_f <= f_mem[tap];
            end
            v2     <= v1;
            first2 <= first1;
            last2  <= last1;
            if (v1) prod <= sat(mul_c);
        end
    end

    // Accumulate with per-step saturation; optional ReLU on the final sum only
    always_comb begin
        acc_base_c = first2 ? '0 : acc;
        sum_c      = PW'(acc_base_c) + PW'(prod);
        sum_sat_c  = sat(sum_c);
`ifdef CONV_STREAM_RELU_EN
        y_c = sum_sat_c[WIDTH-1] ? '0 : sum_sat_c;
`else
        y_c = sum_sat_c;
`endif
    end

    // Accumulator and held output sample
    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            m_data_out_y <= '0;
        end else begin
            if (v2) acc <= sum_sat_c;
            if (v2 && last2) m_data_out_y <= y_c;
        end
    end

endmodule

// File: doc/conv_stream_param.md
CONV_STREAM_PARAM -- requirements
Module: conv_stream_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: data and coefficient width in bits, signed two's complement.
REQ-002 SHALL provide parameter LENX, default 8: input vector length, with LENX >= 2.
REQ-003 SHALL provide parameter LENF, default 4: filter length, with 2 <= LENF <= LENX.
REQ-004 SHALL provide ports as follows.
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- s_data_in_f  in  WIDTH  filter coefficient stream data.
- s_valid_f  in  1  coefficient valid.
- s_ready_f  out  1  block can accept a coefficient.
- s_data_in_x  in  WIDTH  input sample stream data.
- s_valid_x  in  1  sample valid.
- s_ready_x  out  1  block can accept a sample.
- m_data_out_y  out  WIDTH  output sample.
- m_valid_y  out  1  output valid.
- m_ready_y  in  1  downstream ready.

Function
REQ-005 SHALL implement an FSM with states LOAD_F, LOAD_X, COMPUTE and OUTPUT.
REQ-006 A transfer SHALL occur on any posedge where valid and ready are both 1; data is sampled on that edge.
REQ-007 LOAD_F: s_ready_f=1 and s_ready_x=0; SHALL store LENF coefficients into f[0..LENF-1] in arrival order, then enter LOAD_X.
REQ-008 LOAD_X: s_ready_x=1 and s_ready_f=0; SHALL store LENX samples into x[0..LENX-1], then enter COMPUTE on the edge after the last transfer.
REQ-009 COMPUTE SHALL produce y[k] = sum over j=0..LENF-1 of x[k+j]*f[j], for k = 0..LENX-LENF, in ascending order of k.
REQ-010 Each product SHALL be formed at full 2*WIDTH precision, then saturated to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-011 The accumulator SHALL start at 0 for each k; after each addition it SHALL saturate to the signed WIDTH range, applied in order j=0..LENF-1.
REQ-012 The datapath SHALL be pipelined: memory read, then registered multiply, then accumulate, issuing one tap per cycle.
REQ-013 Each y[k] SHALL assert m_valid_y no more than LENF+3 cycles after the COMPUTE or OUTPUT state for that k begins.
REQ-014 OUTPUT: m_valid_y=1; m_data_out_y SHALL hold stable while m_valid_y=1 and m_ready_y=0.
REQ-015 On a y transfer, m_valid_y SHALL drop on the next cycle unless the next y is already complete; the next k's computation SHALL restart in COMPUTE.
REQ-016 The FSM SHALL NOT advance k while OUTPUT is stalled.
REQ-017 After the transfer of y[LENX-LENF], the FSM SHALL enter LOAD_X; the filter is retained for the next vector.
REQ-018 Filter reload SHALL be possible only after reset; s_valid_f outside LOAD_F SHALL be ignored.
REQ-019 s_valid_x outside LOAD_X SHALL be ignored, and no sample SHALL be lost or duplicated.
REQ-020 m_valid_y SHALL never be asserted outside OUTPUT.
REQ-021 s_ready_f and s_ready_x SHALL never be asserted in the same cycle.

Reset
REQ-022 While reset=1 on a posedge, the FSM SHALL enter LOAD_F; all counters and the accumulator SHALL clear; m_valid_y, s_ready_x and s_ready_f SHALL be 0; m_data_out_y SHALL be 0.
REQ-023 Reset asserted in any state, including mid-COMPUTE or stalled OUTPUT, SHALL abort the operation; the partial y SHALL be discarded and coefficients SHALL be reloaded.
REQ-024 s_ready_f SHALL rise on the first cycle after reset deasserts.

Configuration
REQ-025 The macro CONV_STREAM_RELU_EN SHALL control output clamping.
- When defined: any final y[k] < 0 SHALL be output as 0 (ReLU).
- When undefined: y[k] SHALL be the signed saturated value per REQ-011.
- Intermediate accumulation SHALL be identical in both cases.

Verification
REQ-026 WIDTH=8, LENX=8, LENF=4, f={1,1,1,1}, x={1..8}, m_ready_y=1 -> y={10,14,18,22,26}, then s_ready_x=1.
REQ-027 WIDTH=8, f all 127, x all 127 -> every y=127 (saturation); with f all -128 and x all 127 -> every y=-128 without the macro, and 0 with CONV_STREAM_RELU_EN.
REQ-028 f={-1,0,0,0}, x={5,6,7,8,9,10,11,12} -> y={-5,-6,-7,-8,-9} without the macro, and y={0,0,0,0,0} with it.
REQ-029 With the REQ-026 setup, hold m_ready_y=0 for 10 cycles at y[2] -> m_data_out_y=18 stable, s_ready_x=0, and the remaining y values are correct after release.
REQ-030 Assert reset during COMPUTE of y[1], then reload f={2,0,0,0} and x={1..8} -> y={2,4,6,8,10}; no stale output appears.
REQ-031 Random valid/ready toggling on all three streams over 100 vectors -> outputs match the reference model, and REQ-021 holds every cycle.
